clock_divider_multi: RTL and testbench
======================================

# clock_divider_multi

Multi-channel, runtime-programmable clock divider for the camera/IPM datapath. Generates CHANNELS independent divided square waves plus single-cycle tick strobes (clock enables) from one system clock. Divisors reload through a valid/ready config port without glitches, and an optional sync strobe phase-aligns all channels. It replaces the fixed, single-output, compile-time divider used for pixel and sensor timing.

## Interface
- CHANNELS, 4, number of independent output channels (1..16)
- WIDTH, 8, divisor width in bits; legal divisors 2..2^WIDTH-1
- DEFAULT_DIV, 2, divisor loaded into every channel at reset
- CHW (localparam), max(1,$clog2(CHANNELS)), channel-select width
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- en  in  CHANNELS  per-channel run enable, level sensitive
- sync  in  1  one-cycle strobe; restarts all running channels in phase
- cfg_valid  in  1  config request valid
- cfg_ready  out  1  config request accepted when valid&ready at posedge
- cfg_chan  in  CHW  target channel of config request
- cfg_div  in  WIDTH  new divisor
- clk_out  out  CHANNELS  divided square wave per channel, registered
- tick  out  CHANNELS  one-cycle pulse coinciding with each clk_out rising edge, registered
- pending  out  CHANNELS  channel holds an accepted, not-yet-applied divisor

## Operation
- Per channel state: run flag, counter cnt[WIDTH], active divisor D, pending divisor P, pending flag.
- High time H = (D+1)>>1, so the high time is ceil(D/2). Odd D gives one extra high cycle; for example D=3 gives 2 cycles high and 1 low.
- Divisors below 2 written through the config port are clamped to 2 on acceptance.
- Idle (en low): run=0, cnt=0, clk_out=0, tick=0. A pending divisor is applied immediately, and pending clears.
- Start (en high, run=0): run<=1, cnt<=0, clk_out<=1, tick<=1.
- Running: cnt_next = (cnt==D-1) ? 0 : cnt+1.
  - clk_out <= (cnt_next < H).
  - tick <= (cnt_next==0).
- Wrap (cnt==D-1 while running): if pending, D<=P and pending clears on the same edge. H for the new period uses the new D.
- sync high: every channel with en high forces cnt<=0, clk_out<=1, tick<=1, and applies any pending divisor. sync overrides an in-progress wrap. Channels with en low ignore sync.
- Config handshake:
  - cfg_ready = !pending[cfg_chan], combinational.
  - If cfg_chan >= CHANNELS, cfg_ready=1 and the request is accepted and discarded.
  - On accept: P<=clamp(cfg_div) and pending<=1.
- Accept and wrap on the same edge for the same channel: the wrap uses the old pending state. The new value becomes pending and applies at the next wrap.
- en falling mid-period: the output drops to 0 on the next edge with no runt high pulse beyond that edge. Restart begins from cnt=0.

## Timing
- Reset values: clk_out=0, tick=0, pending=0, cnt=0, run=0, D=DEFAULT_DIV. cfg_ready=1 (no channel pending).
- en rise sampled at edge k gives clk_out and tick high after edge k. First period length is D cycles.
- Steady state: tick period D, tick width 1 cycle, clk_out high H cycles then low D-H cycles.
- New divisor latency: it takes effect from the first full period after the next wrap. The worst case is 2^WIDTH-1 cycles after acceptance. Output never shows a period that is neither old D nor new D.
- sync at edge k gives all enabled channels tick=1 after edge k.
- Reset asserted mid-operation clears all outputs asynchronously. Operation resumes from DEFAULT_DIV once rst falls.

## Structure
- Package clock_divider_pkg holds MIN_DIV=2 and a high_time(D) function.
- Sub-module clock_divider_chan implements one channel: counter, D/P registers, run flag, outputs. It is instantiated CHANNELS times via generate.
- The top level holds config decode, cfg_ready mux, and sync fan-out.

## Test plan
- Reset, DEFAULT_DIV=2, en=4'b0001: ch0 toggles every cycle, ticks every 2 cycles; channels 1-3 stay 0.
- Write ch1 div=5 while idle, then en[1]=1: clk_out[1] is 3 high, 2 low, tick every 5 cycles, first tick one cycle after en.
- ch2 running at D=4, write div=7 mid-period: pending[2]=1 and a second write stalls (cfg_ready=0). The remainder of the period stays at 4, the next period is 7, and pending clears at the wrap.
- Write div=0 and div=1: stored as 2. Write cfg_chan=CHANNELS: accepted, no channel changes.
- ch0 at D=3 and ch1 at D=5 running out of phase, then pulse sync: both tick on the next edge and stay aligned every 15 cycles.
- Assert rst mid-high-phase with a pending write: outputs go to 0 immediately. After release, pending=0 and D=DEFAULT_DIV.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   MIN_DIV      : smallest divisor a channel will run with
//   chan_state_e : per-channel run state
//   high_time()  : number of high cycles in a period of length d, ceil(d/2)
package clock_divider_pkg;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } chan_state_e;

  function automatic int unsigned high_time(input int unsigned d);
    return (d + 1) >> 1;
  endfunction

endpackage

// File: rtl/clock_divider_chan.sv
// One divider channel: period counter, active/pending divisor registers,
// run state and registered clk_out/tick outputs.
//   clk, rst   : system clock, asynchronous active-high reset
//   en         : run enable (level)
//   sync       : restart strobe, honoured only while en is high
//   load       : accept load_div as the pending divisor this cycle
//   load_div   : divisor to hold pending (already clamped by the caller)
//   clk_out    : divided square wave, high for ceil(D/2) cycles
//   tick       : one-cycle pulse at each clk_out rising edge
//   pending    : a loaded divisor is waiting for the next period boundary
module clock_divider_chan
  import clock_divider_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [WIDTH-1:0] load_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  chan_state_e      state_q, state_n;
  logic [WIDTH-1:0] cnt_q, cnt_n;
  logic [WIDTH-1:0] d_q, d_n;
  logic [WIDTH-1:0] p_q, p_n;
  logic             pend_q, pend_n;
  logic             clk_n, tick_n;
  logic [WIDTH-1:0] d_last;

  assign d_last  = d_q - WIDTH'(1);
  assign pending = pend_q;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    d_n     = d_q;
    p_n     = p_q;
    pend_n  = pend_q;
    clk_n   = 1'b0;
    tick_n  = 1'b0;

    if (!en) begin
      state_n = CH_IDLE;
      cnt_n   = '0;
      if (pend_q) begin
        d_n    = p_q;
        pend_n = 1'b0;
      end
    end else if (sync || state_q == CH_IDLE) begin
      // Start and sync both begin a fresh period, so a waiting divisor
      // can take over here without cutting a period short.
      state_n = CH_RUN;
      cnt_n   = '0;
      clk_n   = 1'b1;
      tick_n  = 1'b1;
      if (pend_q) begin
        d_n    = p_q;
        pend_n = 1'b0;
      end
    end else if (cnt_q == d_last) begin
      cnt_n  = '0;
      clk_n  = 1'b1;
      tick_n = 1'b1;
      if (pend_q) begin
        d_n    = p_q;
        pend_n = 1'b0;
      end
    end else begin
      cnt_n = cnt_q + WIDTH'(1);
      clk_n = (cnt_n < WIDTH'(high_time(32'(d_q))));
    end

    // A load is only offered while nothing is pending, so it never
    // collides with the clear above; the wrap keeps using the old state.
    if (load) begin
      p_n    = load_div;
      pend_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      d_q     <= WIDTH'(DEFAULT_DIV);
      p_q     <= WIDTH'(DEFAULT_DIV);
      pend_q  <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      d_q     <= d_n;
      p_q     <= p_n;
      pend_q  <= pend_n;
      clk_out <= clk_n;
      tick    <= tick_n;
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel runtime-programmable clock divider.
//   clk, rst  : system clock, asynchronous active-high reset
//   en        : per-channel run enable
//   sync      : restart all enabled channels in phase
//   cfg_valid : config request valid
//   cfg_ready : request accepted when valid & ready at posedge
//   cfg_chan  : target channel (out-of-range requests are accepted and dropped)
//   cfg_div   : new divisor, values below MIN_DIV are stored as MIN_DIV
//   clk_out   : divided square wave per channel
//   tick      : one-cycle strobe at each clk_out rising edge
//   pending   : channel holds an accepted, not yet applied divisor
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter  int unsigned CHANNELS    = 4,
  parameter  int unsigned WIDTH       = 8,
  parameter  int unsigned DEFAULT_DIV = 2,
  localparam int unsigned CHW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHW-1:0]      cfg_chan,
  input  logic [WIDTH-1:0]    cfg_div,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  logic [WIDTH-1:0] div_clamped;

  assign div_clamped = (cfg_div < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : cfg_div;

  // Unmatched (out-of-range) channel numbers leave cfg_ready at 1.
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CHW'(i)) cfg_ready = !pending[i];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic load;
    assign load = cfg_valid && cfg_ready && (cfg_chan == CHW'(g));

    clock_divider_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (en[g]),
      .sync     (sync),
      .load     (load),
      .load_div (div_clamped),
      .clk_out  (clk_out[g]),
      .tick     (tick[g]),
      .pending  (pending[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
module tb_clock_divider_multi;

  localparam int unsigned DEF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] en = '0;
  logic       sync = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_chan = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_ready;
  logic [3:0] clk_out, tick, pending;

  // three-channel instance, so that cfg_chan can address a missing channel
  logic [2:0] en3 = '0;
  logic       cfg_valid3 = 1'b0;
  logic [1:0] cfg_chan3 = '0;
  logic [7:0] cfg_div3 = '0;
  logic       cfg_ready3;
  logic [2:0] clk_out3, tick3, pending3;

  int checks = 0;
  int fails  = 0;

  // reference model: period position, divisor, pending divisor per channel
  int unsigned m_d[4], m_p[4], m_phase[4];
  bit          m_run[4], m_pend[4];

  logic [9:0] vc, vt;

  always #5 clk = ~clk;

  clock_divider_multi #(.CHANNELS(4), .WIDTH(8), .DEFAULT_DIV(DEF)) u_dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan), .cfg_div(cfg_div),
    .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  clock_divider_multi #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIV(DEF)) u_dut3 (
    .clk(clk), .rst(rst), .en(en3), .sync(sync),
    .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3), .cfg_chan(cfg_chan3), .cfg_div(cfg_div3),
    .clk_out(clk_out3), .tick(tick3), .pending(pending3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned clampd(input int unsigned d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_d[i] = DEF; m_p[i] = DEF; m_phase[i] = 0; m_run[i] = 0; m_pend[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit acc;
    for (int i = 0; i < 4; i++) begin
      acc = cfg_valid && (int'(cfg_chan) == i) && !m_pend[i];
      if (!en[i]) begin
        m_run[i] = 0; m_phase[i] = 0;
        if (m_pend[i]) begin m_d[i] = m_p[i]; m_pend[i] = 0; end
      end else if (sync || !m_run[i]) begin
        m_run[i] = 1; m_phase[i] = 0;
        if (m_pend[i]) begin m_d[i] = m_p[i]; m_pend[i] = 0; end
      end else begin
        m_phase[i]++;
        if (m_phase[i] == m_d[i]) begin
          m_phase[i] = 0;
          if (m_pend[i]) begin m_d[i] = m_p[i]; m_pend[i] = 0; end
        end
      end
      if (acc) begin m_p[i] = clampd(cfg_div); m_pend[i] = 1; end
    end
  endtask

  function automatic logic [3:0] exp_clk();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_run[i] && (m_phase[i] < (m_d[i] + 1) / 2);
    return r;
  endfunction

  function automatic logic [3:0] exp_tick();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_run[i] && (m_phase[i] == 0);
    return r;
  endfunction

  function automatic logic [3:0] exp_pend();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_pend[i];
    return r;
  endfunction

  // one clock: check handshake before the edge, outputs just after it
  task automatic step();
    #1;
    chk("cfg_ready", cfg_ready, !m_pend[cfg_chan]);
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    chk("clk_out", clk_out, exp_clk());
    chk("tick", tick, exp_tick());
    chk("pending", pending, exp_pend());
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk_out", clk_out, 4'b0000);
    chk("rst_tick", tick, 4'b0000);
    chk("rst_pending", pending, 4'b0000);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    rst = 1'b0;

    // ch0 at default divisor 2
    en = 4'b0001;
    step(); chk("ch0_first", {tick[0], clk_out[0]}, 2'b11);
    step(); chk("ch0_second", {tick[0], clk_out[0]}, 2'b00);
    repeat (4) step();
    chk("ch1_3_idle", clk_out[3:1], 3'b000);

    // ch1 written while idle, then started
    cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 8'd5;
    step(); cfg_valid = 1'b0;
    chk("ch1_pend_set", pending[1], 1'b1);
    step();
    chk("ch1_pend_idle_apply", pending[1], 1'b0);
    en = 4'b0011;
    vc = '0; vt = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      vc = {vc[8:0], clk_out[1]};
      vt = {vt[8:0], tick[1]};
    end
    chk("ch1_d5_wave", vc, 10'b1110011100);
    chk("ch1_d5_tick", vt, 10'b1000010000);

    // ch2 at D=4, reprogrammed to 7 mid-period
    cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_div = 8'd4;
    step(); cfg_valid = 1'b0;
    step();
    en = 4'b0111;
    step(); step();
    cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_div = 8'd7;
    step();
    chk("ch2_pend", pending[2], 1'b1);
    cfg_div = 8'd9;
    step();
    chk("ch2_stall", cfg_ready, 1'b0);
    chk("ch2_old_period", clk_out[2], 1'b0);
    step();
    cfg_valid = 1'b0;
    chk("ch2_wrap_clear", pending[2], 1'b0);
    chk("ch2_wrap_tick", tick[2], 1'b1);
    vc = '0;
    for (int k = 0; k < 7; k++) begin
      step();
      vc = {vc[8:0], clk_out[2]};
    end
    chk("ch2_d7_wave", vc[6:0], 7'b1110001);

    // clamping of 0 and 1
    cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_div = 8'd0;
    step(); cfg_valid = 1'b0;
    step();
    en = 4'b1111;
    vc = '0;
    for (int k = 0; k < 4; k++) begin step(); vc = {vc[8:0], clk_out[3]}; end
    chk("clamp0_wave", vc[3:0], 4'b1010);
    cfg_valid = 1'b1; cfg_div = 8'd1;
    step(); cfg_valid = 1'b0;
    repeat (4) step();
    vc = '0;
    for (int k = 0; k < 4; k++) begin step(); vc = {vc[8:0], clk_out[3]}; end
    chk("clamp1_wave", (vc[3:0] == 4'b1010) || (vc[3:0] == 4'b0101), 1'b1);

    // request to a channel that does not exist
    cfg_valid3 = 1'b1; cfg_chan3 = 2'd3; cfg_div3 = 8'd7;
    #1 chk("oor_ready", cfg_ready3, 1'b1);
    step();
    chk("oor_pending", pending3, 3'b000);
    chk("oor_clk_out", clk_out3, 3'b000);
    cfg_chan3 = 2'd0;
    step();
    cfg_valid3 = 1'b0;
    chk("ch3inst_pending", pending3, 3'b001);

    // sync alignment of D=3 and D=5
    cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_div = 8'd3;
    step(); cfg_valid = 1'b0;
    en = 4'b0011;
    repeat (7) step();
    sync = 1'b1;
    step(); sync = 1'b0;
    chk("sync_tick", tick[1:0], 2'b11);
    repeat (15) step();
    chk("sync_aligned15", tick[1:0], 2'b11);

    // reset mid-high with a pending write
    cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 8'd9;
    step(); cfg_valid = 1'b0;
    chk("pre_rst_high", {pending[1], clk_out[1]}, 2'b11);
    rst = 1'b1;
    #1;
    chk("async_rst_clk_out", clk_out, 4'b0000);
    chk("async_rst_tick", tick, 4'b0000);
    chk("async_rst_pending", pending, 4'b0000);
    model_reset();
    step(); step();
    rst = 1'b0;
    step(); chk("post_rst_high", clk_out[1], 1'b1);
    step(); chk("post_rst_def", clk_out[1], 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 15) == 0) en[b] = ~en[b];
      sync      = ($urandom_range(0, 39) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_chan  = 2'($urandom_range(0, 3));
      cfg_div   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 9));
      step();
    end
    sync = 1'b0; cfg_valid = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
